dq_write_seq: RTL and testbench

Write-burst sequencer for one DDR3 byte lane, running in the half-rate (divided) memory clock domain. It converts a write command pulse plus a programmable write latency into per-cycle parallel patterns for the output serializers: DQ data, DM, and the DQS strobe with preamble and postamble. It also produces the tristate controls for DQ and DQS and the data-fetch requests to the write buffer. It is the transmit counterpart of the read-capture path and uses the same beat order: bit 3 of every 4-bit group is the first beat on the wire.

---
 rtl/dq_write_seq_pkg.sv | 11 +
 rtl/dq_write_seq_if.sv | 27 ++
 rtl/dq_write_sched.sv | 46 ++++
 rtl/dq_write_seq.sv | 59 +++++
 tb/tb_dq_write_seq.sv | 139 +++++++++++++
 5 files changed

// File: rtl/dq_write_seq_pkg.sv
// dq_write_seq_pkg: strobe patterns, burst length and beat order shared by the lane write and read paths
package dq_write_seq_pkg;
  localparam logic [3:0] DQS_DATA = 4'b1010;
  localparam logic [3:0] DQS_IDLE = 4'b0000;
  localparam int BL8_CYCLES = 2;
  // Bit 3 of every 4-bit group is the first beat on the wire.
  localparam int BEAT0_BIT = 3;
  function automatic int beat_lsb(input int b, input int w);
    return (BEAT0_BIT - b) * w;
  endfunction
endpackage

// File: rtl/dq_write_seq_if.sv
// dq_write_seq_if: write-command side and serializer side of one DDR3 byte-lane write sequencer
// master: drives wr_start/wlat/wdata/wdm, receives the serializer patterns and status
// slave : the sequencer itself
interface dq_write_seq_if #(
  parameter int DQ_WIDTH = 8
);
  logic                  wr_start;
  logic [3:0]            wlat;
  logic [4*DQ_WIDTH-1:0] wdata;
  logic [3:0]            wdm;
  logic                  data_req;
  logic [4*DQ_WIDTH-1:0] dq_par;
  logic [3:0]            dm_par;
  logic                  dq_tri;
  logic [3:0]            dqs_par;
  logic                  dqs_tri;
  logic                  wr_busy;
  logic                  wr_err;
  modport master (
    output wr_start, wlat, wdata, wdm,
    input  data_req, dq_par, dm_par, dq_tri, dqs_par, dqs_tri, wr_busy, wr_err
  );
  modport slave (
    input  wr_start, wlat, wdata, wdm,
    output data_req, dq_par, dm_par, dq_tri, dqs_par, dqs_tri, wr_busy, wr_err
  );
endinterface

// File: rtl/dq_write_sched.sv
// dq_write_sched: burst schedule shift register, accept/drop check and window decode
// in : clk, rst_n, wr_start, wlat
// out: req_nx/data_nx/strb_nx/busy_nx (values for the next cycle), wr_err (sticky)
module dq_write_sched
  import dq_write_seq_pkg::*;
#(
  parameter int WLAT_MIN = 3,
  parameter int WLAT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_start,
  input  logic [3:0] wlat,
  output logic       req_nx,
  output logic       data_nx,
  output logic       strb_nx,
  output logic       busy_nx,
  output logic       wr_err
);
  localparam int SW = WLAT_MAX + 2;
  localparam logic [SW+1:0] WIN3 = {{(SW-1){1'b0}}, 3'b111};
  logic [SW-1:0] sched, sh, nx;
  logic [SW+1:0] win;
  logic          ok;
  // A burst sits at bit p of sched when its first data cycle is p-1 cycles away;
  // the new start is judged against the already-shifted schedule it will join.
  always_comb begin
    sh = sched >> 1;
    win = {1'b0, sh, 1'b0} & (WIN3 << wlat);
    ok = wr_start && {1'b0, wlat} >= 5'(WLAT_MIN) && {1'b0, wlat} <= 5'(WLAT_MAX) && !(|win);
    nx = sh | (ok ? SW'(1) << wlat : '0);
  end
  assign req_nx  = |nx[BL8_CYCLES+1:BL8_CYCLES];
  assign data_nx = |nx[BL8_CYCLES-1:0];
  // sched[0] is the last data cycle, so it keeps the strobe up for the postamble.
  assign strb_nx = |nx[BL8_CYCLES:0] | sched[0];
  assign busy_nx = |nx | strb_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sched  <= '0;
      wr_err <= 1'b0;
    end else begin
      sched  <= nx;
      wr_err <= wr_err | (wr_start & ~ok);
    end
endmodule

// File: rtl/dq_write_seq.sv
// dq_write_seq: half-rate DDR3 byte-lane write-burst sequencer feeding the DQ/DM/DQS serializers
// in : clk, rst_n, bus.wr_start, bus.wlat, bus.wdata, bus.wdm
// out: bus.data_req, bus.dq_par, bus.dm_par, bus.dq_tri, bus.dqs_par, bus.dqs_tri, bus.wr_busy, bus.wr_err
module dq_write_seq
  import dq_write_seq_pkg::*;
#(
  parameter int DQ_WIDTH = 8,
  parameter int WLAT_MIN = 3,
  parameter int WLAT_MAX = 15
) (
  input logic           clk,
  input logic           rst_n,
  dq_write_seq_if.slave bus
);
  logic                  req_nx, data_nx, strb_nx, busy_nx, err;
  logic                  req_q, dq_tri_q, dqs_tri_q, busy_q;
  logic [4*DQ_WIDTH-1:0] dq_q;
  logic [3:0]            dm_q, dqs_q;
  dq_write_sched #(
    .WLAT_MIN(WLAT_MIN),
    .WLAT_MAX(WLAT_MAX)
  ) u_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_start(bus.wr_start),
    .wlat    (bus.wlat),
    .req_nx  (req_nx),
    .data_nx (data_nx),
    .strb_nx (strb_nx),
    .busy_nx (busy_nx),
    .wr_err  (err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_q     <= 1'b0;
      dq_q      <= '0;
      dm_q      <= '0;
      dqs_q     <= DQS_IDLE;
      dq_tri_q  <= 1'b1;
      dqs_tri_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      req_q     <= req_nx;
      dq_q      <= data_nx ? bus.wdata : '0;
      dm_q      <= data_nx ? bus.wdm : '0;
      dqs_q     <= data_nx ? DQS_DATA : DQS_IDLE;
      dq_tri_q  <= ~data_nx;
      dqs_tri_q <= ~strb_nx;
      busy_q    <= busy_nx;
    end
  assign bus.data_req = req_q;
  assign bus.dq_par   = dq_q;
  assign bus.dm_par   = dm_q;
  assign bus.dqs_par  = dqs_q;
  assign bus.dq_tri   = dq_tri_q;
  assign bus.dqs_tri  = dqs_tri_q;
  assign bus.wr_busy  = busy_q;
  assign bus.wr_err   = err;
endmodule

// File: tb/tb_dq_write_seq.sv
// tb_dq_write_seq: directed window tables, reset corner case and randomized model check of dq_write_seq
module tb_dq_write_seq;
  import dq_write_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dq_write_seq_if #(.DQ_WIDTH(8)) bus ();
  dq_write_seq #(.DQ_WIDTH(8), .WLAT_MIN(3), .WLAT_MAX(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int          la;
    int          gap;
    int          lb;
    logic [23:0] req;
    logic [23:0] dqd;
    logic [23:0] dqsd;
    logic        err;
  } vec_t;
  vec_t tbl [13];
  int n_chk = 0;
  int n_pass = 0;
  logic [35:0] hist [0:4095];
  localparam logic [63:0] NO_STAT = ~64'h3;
  task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, t, act, exp);
  endtask
  function automatic logic [63:0] outs();
    return 64'({bus.data_req, bus.dq_tri, bus.dqs_tri, bus.dqs_par, bus.dm_par, bus.dq_par, bus.wr_busy, bus.wr_err});
  endfunction
  function automatic logic [63:0] mk(input logic req, input logic data, input logic drv,
                                     input logic [35:0] d, input logic busy, input logic err);
    return 64'({req, ~data, ~drv, data ? 4'b1010 : 4'b0000, data ? d : 36'h0, busy, err});
  endfunction
  task automatic drive(input int t, input logic st, input int l);
    bus.wr_start = st;
    bus.wlat = 4'(l);
    bus.wdata = $urandom;
    bus.wdm = 4'($urandom);
    hist[t] = {bus.wdm, bus.wdata};
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.wr_start = 1'b0;
    bus.wlat = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset", -1, outs(), mk(0, 0, 0, 36'h0, 0, 0));
    rst_n = 1'b1;
  endtask
  initial begin
    int bq[$];
    int rc, l, dd;
    logic st, acc, merr, req, data, drv, busy;
    bus.wr_start = 1'b0;
    bus.wlat = 4'd0;
    bus.wdata = '0;
    bus.wdm = '0;
    tbl[0]  = '{5, 0, 0, 24'h000018, 24'h000060, 24'h0000F0, 1'b0};
    tbl[1]  = '{4, 2, 4, 24'h00003C, 24'h0000F0, 24'h0001F8, 1'b0};
    tbl[2]  = '{4, 5, 4, 24'h00018C, 24'h000630, 24'h000F78, 1'b0};
    tbl[3]  = '{6, 1, 6, 24'h000030, 24'h0000C0, 24'h0001E0, 1'b1};
    tbl[4]  = '{2, 0, 0, 24'h000000, 24'h000000, 24'h000000, 1'b1};
    tbl[5]  = '{4, 3, 4, 24'h00006C, 24'h0001B0, 24'h0003F8, 1'b0};
    tbl[6]  = '{4, 4, 4, 24'h0000CC, 24'h000330, 24'h0007F8, 1'b0};
    tbl[7]  = '{3, 5, 3, 24'h0000C6, 24'h000318, 24'h0007BC, 1'b0};
    tbl[8]  = '{8, 3, 3, 24'h0000F0, 24'h0003C0, 24'h0007E0, 1'b0};
    tbl[9]  = '{8, 3, 4, 24'h0000C0, 24'h000300, 24'h000780, 1'b1};
    tbl[10] = '{15, 0, 0, 24'h006000, 24'h018000, 24'h03C000, 1'b0};
    tbl[11] = '{3, 0, 0, 24'h000006, 24'h000018, 24'h00003C, 1'b0};
    tbl[12] = '{0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 1'b1};
    for (int v = 0; v < 13; v++) begin
      do_reset();
      for (int t = 0; t < 24; t++) begin
        @(negedge clk);
        chk($sformatf("vec%0d", v), t, outs() & NO_STAT,
            mk(tbl[v].req[t], tbl[v].dqd[t], tbl[v].dqsd[t], t > 0 ? hist[t-1] : 36'h0, 0, 0) & NO_STAT);
        drive(t, t == 0 || (tbl[v].gap != 0 && t == tbl[v].gap), t == 0 ? tbl[v].la : tbl[v].lb);
      end
      chk($sformatf("vec%0d wr_err", v), 24, 64'(bus.wr_err), 64'(tbl[v].err));
      chk($sformatf("vec%0d wr_busy", v), 24, 64'(bus.wr_busy), 64'h0);
    end
    do_reset();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      drive(t, t == 0, 5);
    end
    chk("dq driven before reset", 5, 64'(bus.dq_tri), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("async tristate", 5, 64'({bus.dq_tri, bus.dqs_tri}), 64'h3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk("post reset idle", t, 64'({bus.data_req, bus.wr_busy, bus.dq_tri, bus.dqs_tri}), 64'h3);
      drive(t, 1'b0, 0);
    end
    do_reset();
    merr = 1'b0;
    rc = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      req = 1'b0;
      data = 1'b0;
      drv = 1'b0;
      busy = 1'b0;
      foreach (bq[i]) begin
        dd = bq[i];
        req |= (t == dd - 2 || t == dd - 1);
        data |= (t == dd || t == dd + 1);
        drv |= (t >= dd - 1 && t <= dd + 2);
        busy |= (t <= dd + 2);
      end
      if (!rst_n) chk("rand reset", t, outs(), mk(0, 0, 0, 36'h0, 0, 0));
      else chk("rand", t, outs(), mk(req, data, drv, t > 0 ? hist[t-1] : 36'h0, busy, merr));
      if (rc > 0) begin
        rc--;
        if (rc == 0) rst_n = 1'b1;
        drive(t, 1'b0, 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        rc = 2;
        bq.delete();
        merr = 1'b0;
        drive(t, 1'b0, 0);
      end else begin
        st = ($urandom_range(0, 2) == 0);
        l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 15);
        acc = (l >= 3 && l <= 15);
        foreach (bq[i]) if (bq[i] - (t + l) <= 1 && (t + l) - bq[i] <= 1) acc = 1'b0;
        if (st && acc) bq.push_back(t + l);
        if (st && !acc) merr = 1'b1;
        drive(t, st, l);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
